// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and width constants shared by the
// bit-serial adder files.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder (fa) assembled from two half-adder cells (ha)
// with an OR merging their carries.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0_s;
    logic c0_s;
    logic c1_s;

    ha u_ha0 (.a(a),    .b(b),  .s(s0_s), .c(c0_s));
    ha u_ha1 (.a(s0_s), .b(ci), .s(s),    .c(c1_s));

    assign co = c0_s | c1_s;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock LSB-first.
// Defining SERIAL_ADDER_SUB_EN adds the sub port for A-B via ~B and carry-in 1.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_sh_s;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_init_s;
    logic             fa_b_s;
    logic             fa_s_s;
    logic             fa_co_s;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;
    assign carry_init_s = sub;
    assign fa_b_s       = b_sr_q[0] ^ sub_q;
`else
    assign carry_init_s = 1'b0;
    assign fa_b_s       = b_sr_q[0];
`endif

    fa u_fa (
        .a  (a_sr_q[0]),
        .b  (fa_b_s),
        .ci (carry_q),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

    // Next-state, datapath and output computation
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_sh_s = {fa_s_s, sum_sr_q};
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d    = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = carry_init_s;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            RUN: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                sum_sr_d = sum_sh_s[WIDTH-1:1];
                carry_d  = fa_co_s;
                cnt_d    = cnt_q + CW'(1);
                // The last bit goes straight into the output register.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = sum_sh_s;
                    cout_d  = fa_co_s;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= {WIDTH{1'b0}};
            b_sr_q   <= {WIDTH{1'b0}};
            sum_sr_q <= {(WIDTH-1){1'b0}};
            cnt_q    <= {CW{1'b0}};
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard queue filled by the
// stimulus side, drained by a monitor on every done pulse.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic; result packed as {cout, sum}.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic s);
        int unsigned xv = x;
        int unsigned yv = y;
        logic [WIDTH-1:0] d;
        if (s) begin
            d = WIDTH'(xv - yv);
            return {(xv >= yv), d};
        end else begin
            return (WIDTH+1)'(xv + yv);
        end
    endfunction

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (rst_n === 1'b1) begin
            if (busy === 1'b1 && done === 1'b1) check("busy_done_excl", 64'd1, 64'd0);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 64'(sum), 64'(e[WIDTH-1:0]));
                    check("cout", 64'(cout), 64'(e[WIDTH]));
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (!(busy === 1'b0 && done === 1'b0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tsub, input bit disturb);
        int busy_cycles = 0;
        int done_at = 0;
        int extra = 0;
        wait_idle();
        a = ta;
        b = tb_v;
`ifdef SERIAL_ADDER_SUB_EN
        sub = tsub;
`endif
        start = 1'b1;
        exp_q.push_back(model(ta, tb_v, tsub));
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        for (int i = 1; i <= WIDTH + 4; i++) begin
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            if (disturb) begin
                a = {WIDTH{1'b1}};
                b = {WIDTH{1'b1}};
                start = (i == 3);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_latency", 64'(done_at), 64'(WIDTH + 1));
        check("busy_cycles", 64'(busy_cycles), 64'(WIDTH));
        if (disturb) begin
            repeat (WIDTH + 3) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check("no_extra_done", 64'(extra), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done = 0;
        int second_done = 0;
        int extra = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);

        // start held high: second run only after DONE, pulses WIDTH+2 apart
        wait_idle();
        a = 8'h01;
        b = 8'h02;
        start = 1'b1;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        for (int i = 1; i <= 3 * WIDTH + 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (first_done == 0) first_done = i;
                else begin
                    second_done = i;
                    break;
                end
            end
        end
        start = 1'b0;
        check("first_done_latency", 64'(first_done), 64'(WIDTH + 1));
        check("done_spacing", 64'(second_done - first_done), 64'(WIDTH + 2));

        // reset in the middle of RUN discards the partial result
        wait_idle();
        a = 8'hF0;
        b = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("no_done_after_reset", 64'(extra), 64'd0);

        // operands switched and start pulsed during RUN
        run_op(8'h11, 8'h22, 1'b0, 1'b1);

        for (int k = 0; k < 20; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0);
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 1'b0);
        run_op(8'h01, 8'h02, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        end
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
